// File: rtl/red_pitaya_pll_pkg.sv
// Shared types and constants for the PLLE2_ADV runtime reconfiguration controller.
// Holds the FSM state enum, DRP address table, keep-masks and error codes.
package red_pitaya_pll_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_RST,
        S_RD,
        S_RD_W,
        S_WR,
        S_WR_W,
        S_NEXT,
        S_REL,
        S_LOCK_W
    } state_t;

    // Bits of ClkReg1/ClkReg2 that must survive the read-modify-write
    localparam logic [15:0] KEEP_REG1 = 16'hF000;
    localparam logic [15:0] KEEP_REG2 = 16'hFF3F;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_DIV  = 2'd1;
    localparam logic [1:0] ERR_DRP  = 2'd2;
    localparam logic [1:0] ERR_LOCK = 2'd3;

    localparam logic [6:0] DIV_MAX = 7'd126;

    // ClkReg1 address for a CLKOUT channel; ClkReg2 is the next address.
    // CLKOUT5 sits below CLKOUT0 in the DRP map.
    function automatic logic [6:0] clk_addr(input logic [2:0] ch,
                                            input logic       r);
        logic [6:0] base;
        case (ch)
            3'd0:    base = 7'h08;
            3'd1:    base = 7'h0A;
            3'd2:    base = 7'h0C;
            3'd3:    base = 7'h0E;
            3'd4:    base = 7'h10;
            default: base = 7'h06;
        endcase
        return base | {6'd0, r};
    endfunction

endpackage

// File: rtl/red_pitaya_pll_div_enc.sv
// Combinational encoder: merges a CLKOUT divider into DRP read data.
// Ports: div_i divider, rdata_i read word, reg1_o/reg2_o merged ClkReg1/ClkReg2.
module red_pitaya_pll_div_enc
    import red_pitaya_pll_pkg::*;
(
    input  logic [6:0]  div_i,
    input  logic [15:0] rdata_i,
    output logic [15:0] reg1_o,
    output logic [15:0] reg2_o
);

    logic [5:0] hi;
    logic [5:0] lo;

    // lo = d - hi; computed modulo 64, exact for every legal divider
    assign hi = div_i[6:1];
    assign lo = div_i[5:0] - hi;

    assign reg1_o = (rdata_i & KEEP_REG1) | {4'd0, hi, lo};
    assign reg2_o = (rdata_i & KEEP_REG2)
                  | {8'd0, div_i[0], (div_i == 7'd1), 6'd0};

endmodule

// File: rtl/red_pitaya_pll_cfg.sv
// Runtime PLLE2_ADV divider reconfiguration over DRP with lock wait.
// Ports: cfg_* request, busy/done/err status, pll_* PLL control, drp_* DRP bus.
module red_pitaya_pll_cfg
    import red_pitaya_pll_pkg::*;
#(
    parameter int NCH          = 6,
    parameter int DRP_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int CW           = 17
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [NCH-1:0]   cfg_mask,
    input  logic [NCH*7-1:0] cfg_div,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic             locked,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic [6:0]       drp_daddr,
    output logic [15:0]      drp_di,
    output logic             drp_den,
    output logic             drp_dwe,
    input  logic [15:0]      drp_do,
    input  logic             drp_drdy
);

    localparam int DW = $clog2(DRP_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [NCH*7-1:0] div_q, div_d;
    logic [1:0]       err_q, err_d;
    logic [2:0]       ch_q, ch_d;
    logic             r_q, r_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [CW-1:0]    lcnt_q, lcnt_d;
    logic             busy_q, done_q, rst_q;
    logic             den_q, den_d;
    logic             dwe_q, dwe_d;
    logic [6:0]       daddr_q, daddr_d;
    logic [15:0]      di_q, di_d;
    logic             sync1_q, sync2_q;

    logic             div_bad;
    logic             nxt_ok;
    logic [2:0]       nxt_ch;
    logic [6:0]       cur_div;
    logic [15:0]      enc_reg1, enc_reg2;

    always_comb begin
        div_bad = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (mask_q[i] && (div_q[i*7 +: 7] == 7'd0 ||
                              div_q[i*7 +: 7] > DIV_MAX))
                div_bad = 1'b1;
        end
    end

    // Lowest enabled channel above the current one (any channel in RST);
    // the descending loop leaves the lowest match as the final assignment.
    always_comb begin
        nxt_ok = 1'b0;
        nxt_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (state_q == S_RST || 3'(i) > ch_q)) begin
                nxt_ok = 1'b1;
                nxt_ch = 3'(i);
            end
        end
    end

    always_comb begin
        cur_div = '0;
        for (int i = 0; i < NCH; i++) begin
            if (3'(i) == ch_q)
                cur_div = div_q[i*7 +: 7];
        end
    end

    // Merge straight from drp_do so the write word is ready as WR begins
    red_pitaya_pll_div_enc u_enc (
        .div_i   (cur_div),
        .rdata_i (drp_do),
        .reg1_o  (enc_reg1),
        .reg2_o  (enc_reg2)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        div_d   = div_q;
        err_d   = err_q;
        ch_d    = ch_q;
        r_d     = r_q;
        dcnt_d  = dcnt_q;
        lcnt_d  = lcnt_q;
        den_d   = 1'b0;
        dwe_d   = 1'b0;
        daddr_d = daddr_q;
        di_d    = di_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    mask_d  = cfg_mask;
                    div_d   = cfg_div;
                    err_d   = ERR_OK;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (div_bad) begin
                    err_d   = ERR_DIV;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RST;
                end
            end
            S_RST: begin
                r_d = 1'b0;
                if (nxt_ok) begin
                    ch_d    = nxt_ch;
                    daddr_d = clk_addr(nxt_ch, 1'b0);
                    den_d   = 1'b1;
                    state_d = S_RD;
                end else begin
                    state_d = S_REL;
                end
            end
            S_RD: begin
                dcnt_d  = '0;
                state_d = S_RD_W;
            end
            S_RD_W: begin
                if (drp_drdy) begin
                    di_d    = r_q ? enc_reg2 : enc_reg1;
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    state_d = S_WR;
                end else if (dcnt_q == DW'(DRP_TIMEOUT - 1)) begin
                    err_d   = ERR_DRP;
                    state_d = S_REL;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            S_WR: begin
                dcnt_d  = '0;
                state_d = S_WR_W;
            end
            S_WR_W: begin
                if (drp_drdy) begin
                    state_d = S_NEXT;
                end else if (dcnt_q == DW'(DRP_TIMEOUT - 1)) begin
                    err_d   = ERR_DRP;
                    state_d = S_REL;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            S_NEXT: begin
                if (!r_q) begin
                    r_d     = 1'b1;
                    daddr_d = clk_addr(ch_q, 1'b1);
                    den_d   = 1'b1;
                    state_d = S_RD;
                end else if (nxt_ok) begin
                    r_d     = 1'b0;
                    ch_d    = nxt_ch;
                    daddr_d = clk_addr(nxt_ch, 1'b0);
                    den_d   = 1'b1;
                    state_d = S_RD;
                end else begin
                    state_d = S_REL;
                end
            end
            S_REL: begin
                lcnt_d  = '0;
                state_d = (err_q != ERR_OK) ? S_IDLE : S_LOCK_W;
            end
            S_LOCK_W: begin
                if (sync2_q) begin
                    state_d = S_IDLE;
                end else if (lcnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    err_d   = ERR_LOCK;
                    state_d = S_IDLE;
                end else begin
                    lcnt_d = lcnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            div_q   <= '0;
            err_q   <= ERR_OK;
            ch_q    <= '0;
            r_q     <= 1'b0;
            dcnt_q  <= '0;
            lcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rst_q   <= 1'b0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            daddr_q <= '0;
            di_q    <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            div_q   <= div_d;
            err_q   <= err_d;
            ch_q    <= ch_d;
            r_q     <= r_d;
            dcnt_q  <= dcnt_d;
            lcnt_q  <= lcnt_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q != S_IDLE) && (state_d == S_IDLE);
            rst_q   <= state_d inside {S_RST, S_RD, S_RD_W,
                                       S_WR, S_WR_W, S_NEXT};
            den_q   <= den_d;
            dwe_q   <= dwe_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    assign cfg_ready = !busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign locked    = sync2_q;
    assign pll_rst   = rst_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign drp_daddr = daddr_q;
    assign drp_di    = di_q;

endmodule

// File: doc/red_pitaya_pll_cfg.md
# red_pitaya_pll_cfg

Runtime reconfiguration controller for the PLLE2_ADV clock generator. It accepts a new divider set for up to six CLKOUT channels and programs the PLL through its DRP port using read-modify-write. The PLL is held in reset during programming, then released, and the controller waits for lock with a timeout. It sits beside the PLL wrapper in the clock subsystem and is driven by the housekeeping register bank in the `clk` domain.

## Interface
- `NCH`, 6 — number of CLKOUT channels handled, 1..6; channel n maps to CLKOUTn.
- `DRP_TIMEOUT`, 64 — maximum cycles to wait for `drp_drdy` per access.
- `LOCK_TIMEOUT`, 65536 — maximum cycles to wait for lock after PLL reset release.
- `CW`, 17 — width of the lock-timeout counter; must satisfy 2^CW > LOCK_TIMEOUT.

- `clk` in 1 — controller clock; the same clock drives the PLL DRP `DCLK`.
- `rstn` in 1 — asynchronous, active-low reset.
- `cfg_valid` in 1 — request valid.
- `cfg_ready` out 1 — controller idle; a request is accepted when `cfg_valid && cfg_ready`.
- `cfg_mask` in NCH — per-channel enable; channels whose bit is 0 are not touched.
- `cfg_div` in NCH×7 — packed divider per channel; legal range 1..126.
- `busy` out 1 — high from accept until the sequence ends.
- `done` out 1 — one-cycle pulse when the sequence ends, on success or on error.
- `err` out 2 — sticky until the next accept: 0 = ok, 1 = illegal divider, 2 = DRP timeout, 3 = lock timeout.
- `locked` out 1 — `pll_locked` after a 2-FF synchroniser.
- `pll_locked` in 1 — PLL `LOCKED`; asynchronous.
- `pll_rst` out 1 — ORed into the PLL `RST` outside this block.
- `drp_daddr` out 7, `drp_di` out 16, `drp_den` out 1, `drp_dwe` out 1 — DRP request signals.
- `drp_do` in 16, `drp_drdy` in 1 — DRP response signals.

## Operation
- States: IDLE → CHECK → RST → RD → RD_W → WR → WR_W → NEXT → REL → LOCK_W → IDLE.
- **IDLE**
  - `cfg_ready` = 1.
  - On accept: latch `cfg_mask` and `cfg_div`, clear `err`, assert `busy`.
  - Go to CHECK.
- **CHECK**
  - If any enabled channel has `div` = 0 or `div` > 126: `err` = 1, pulse `done`, go to IDLE.
  - In this case there is no DRP access and `pll_rst` is never asserted.
- **RST**
  - `pll_rst` = 1.
  - Reg index r = 0; channel = lowest enabled channel.
  - If the mask is all-zero, go straight to REL.
- **Register fields** for divider d, with hi = d>>1 and lo = d − hi:
  - ClkReg1 write value = {keep[15:12], hi[5:0], lo[5:0]}.
  - ClkReg2 write value = {keep[15:8], edge = d[0], nocount = (d == 1), keep[5:0]}.
  - For d = 1: hi = 0, lo = 1, nocount = 1.
- **Addresses (ClkReg1/ClkReg2)**: CLKOUT0 08/09, CLKOUT1 0A/0B, CLKOUT2 0C/0D, CLKOUT3 0E/0F, CLKOUT4 10/11, CLKOUT5 06/07.
- **RD**
  - Drive `drp_daddr`; `drp_den` = 1 for one cycle.
  - RD_W waits for `drp_drdy`, then captures `drp_do`.
- **WR**
  - `drp_di` = merged value; `drp_den` = `drp_dwe` = 1 for one cycle.
  - WR_W waits for `drp_drdy`.
- **NEXT**
  - r = 0 → r = 1, same channel.
  - r = 1 → next enabled channel, or REL if none remain.
  - Channels are processed in ascending order.
- **DRP timeout**: counter of cycles in RD_W or WR_W reaches `DRP_TIMEOUT` → `err` = 2, go to REL; the remaining channels are skipped.
- **REL**
  - `pll_rst` = 0.
  - If `err` ≠ 0: pulse `done`, go to IDLE.
  - Otherwise go to LOCK_W.
- **LOCK_W**
  - `locked` = 1 → pulse `done`, go to IDLE.
  - Counter reaches `LOCK_TIMEOUT` → `err` = 3, pulse `done`, go to IDLE.
- `cfg_valid` while busy is ignored; there is no queuing.
- `drp_drdy` outside RD_W/WR_W is ignored.
- Reset mid-sequence returns to IDLE immediately and drops `pll_rst`; the PLL restarts with whatever mix of registers was written. Software must re-issue the configuration.

## Timing
- Reset values:
  - `cfg_ready` = 1; `busy` = `done` = 0; `err` = 0; `locked` = 0; `pll_rst` = 0.
  - All `drp_*` outputs = 0.
- Cycle-level latency:
  - Accept at cycle 0; CHECK at cycle 1; `pll_rst` rises at cycle 2.
  - First `drp_den` at cycle 3.
  - Each access takes 2 + (drdy latency) cycles.
- `done` is registered and coincides with `busy` falling; `cfg_ready` rises in the same cycle.
- `locked` lags `pll_locked` by 2 cycles.
- `drp_den` is never high in two consecutive cycles.
- `pll_rst` is high continuously from cycle 2 until REL.

## Structure
- Package `red_pitaya_pll_pkg` holds:
  - the state enum;
  - the ClkReg1/ClkReg2 address table as a function of channel index;
  - keep-masks `16'hF000` (ClkReg1) and `16'hFF3F` (ClkReg2);
  - the error codes.
- Sub-module `red_pitaya_pll_div_enc` (combinational): takes divider plus read data and returns the merged ClkReg1/ClkReg2 words.

## Test plan
- Mask `6'b000001`, div0 = 10, DRP model with 3-cycle drdy and register 08 = `16'hF0C3` → writes 08 = `16'hF145`; 09 is written with edge = 0 and nocount = 0; `locked` asserted after 100 cycles; `done` pulses; `err` = 0.
- All 6 channels, div = {1, 2, 3, 8, 126, 7} → 24 accesses in address order 08, 09, 0A, …, 07; div 1 gives nocount = 1; div 126 gives hi = lo = 63.
- div0 = 0 with mask bit 0 set → `done` at cycle 2, `err` = 1; no `drp_den`; `pll_rst` never rises.
- DRP model never returns drdy → `err` = 2 after 64 cycles; `pll_rst` falls; no further accesses.
- `pll_locked` held low → `err` = 3 after `LOCK_TIMEOUT` cycles; `cfg_valid` pulsed while busy is ignored.
- Assert `rstn` low during WR_W → all outputs return to reset values asynchronously; a new request is then accepted normally.
